// File: rtl/au_prefix_pkg.sv
// Shared helpers for the prefix/suffix AND family.
// Parameter bounds and cycle-count arithmetic.
package au_prefix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } au_state_e;

  localparam int LPC_MIN = 1;

  function automatic int au_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int au_max_lpc(input int width);
    int l;
    l = au_clog2(width);
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int au_num_cycles(
    input int width,
    input int lpc
  );
    int l;
    int c;
    l = au_clog2(width);
    c = (l + lpc - 1) / lpc;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/au_suffix_and_level.sv
// One suffix-AND level: q[i] = p[i] & p[i + 2^j].
// Indices j >= MAXL leave the word untouched.
module au_suffix_and_level #(
  parameter int WIDTH = 8,
  parameter int MAXL  = 3
) (
  input  logic [7:0]       j,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q
);

  // Select the level matching j and combine with the bit 2^j above.
  always_comb begin
    q = p;
    for (int lv = 0; lv < MAXL; lv++) begin
      if (j == 8'(lv)) begin
        for (int i = 0; i < WIDTH - (1 << lv); i++) begin
          q[i] = p[i] & p[i + (1 << lv)];
        end
      end
    end
  end

endmodule

// File: rtl/au_suffix_and_seq.sv
// Multi-cycle suffix-AND with valid/ready handshake.
// LVL_PER_CYC levels are applied per clock to one register.
module au_suffix_and_seq
  import au_prefix_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LVL_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] po
);

  localparam int L = au_clog2(WIDTH);
  localparam logic [7:0] L8 = 8'(L);
  localparam logic [7:0] STEP = 8'(LVL_PER_CYC);

  generate
    if (WIDTH < 1 || LVL_PER_CYC < LPC_MIN ||
        LVL_PER_CYC > au_max_lpc(WIDTH)) begin : g_bad
      $fatal(1, "au_suffix_and_seq: illegal WIDTH/LVL_PER_CYC");
    end
  endgenerate

  au_state_e        state;
  au_state_e        state_nxt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_nxt;
  logic [7:0]       k;
  logic [7:0]       k_nxt;
  logic [7:0]       k_sum;
  logic [WIDTH-1:0] stage [LVL_PER_CYC+1];

  assign stage[0] = p;

  for (genvar m = 0; m < LVL_PER_CYC; m++) begin : g_lvl
    au_suffix_and_level #(
      .WIDTH (WIDTH),
      .MAXL  (L)
    ) u_lvl (
      .j (k + 8'(m)),
      .p (stage[m]),
      .q (stage[m+1])
    );
  end

  assign k_sum = k + STEP;

  // Next state, next word and level counter.
  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    k_nxt     = k;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          p_nxt     = pi;
          k_nxt     = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        p_nxt = stage[LVL_PER_CYC];
        k_nxt = k_sum;
        if (k_sum >= L8) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working word and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      k     <= k_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign po        = (state == DONE) ? p : '0;

endmodule

// File: tb/tb_au_suffix_and_seq.sv
// Bench for au_suffix_and_seq over four configurations.
// Results are checked against a plain suffix-AND model.
module tb_au_suffix_and_seq;

  logic clk;
  logic rst_n;

  logic       a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_pi, a_po;
  logic       b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_pi, b_po;
  logic       c_iv, c_ir, c_ov, c_or;
  logic [0:0] c_pi, c_po;
  logic        d_iv, d_ir, d_ov, d_or;
  logic [12:0] d_pi, d_po;

  int checks = 0;
  int errors = 0;

  au_suffix_and_seq #(.WIDTH(8), .LVL_PER_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .pi(a_pi), .out_valid(a_ov), .out_ready(a_or), .po(a_po));
  au_suffix_and_seq #(.WIDTH(8), .LVL_PER_CYC(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .pi(b_pi), .out_valid(b_ov), .out_ready(b_or), .po(b_po));
  au_suffix_and_seq #(.WIDTH(1), .LVL_PER_CYC(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .pi(c_pi), .out_valid(c_ov), .out_ready(c_or), .po(c_po));
  au_suffix_and_seq #(.WIDTH(13), .LVL_PER_CYC(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
    .pi(d_pi), .out_valid(d_ov), .out_ready(d_or), .po(d_po));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] sfx(input logic [12:0] v, input int w);
    logic acc;
    logic [12:0] r;
    acc = 1'b1;
    r = '0;
    for (int i = w - 1; i >= 0; i--) begin
      acc = acc & v[i];
      r[i] = acc;
    end
    return r;
  endfunction

  function automatic logic get_ov(input int s);
    case (s)
      0: return a_ov;
      1: return b_ov;
      2: return c_ov;
      default: return d_ov;
    endcase
  endfunction

  function automatic logic get_ir(input int s);
    case (s)
      0: return a_ir;
      1: return b_ir;
      2: return c_ir;
      default: return d_ir;
    endcase
  endfunction

  function automatic logic [12:0] get_po(input int s);
    case (s)
      0: return {5'b0, a_po};
      1: return {5'b0, b_po};
      2: return {12'b0, c_po};
      default: return d_po;
    endcase
  endfunction

  task automatic set_in(input int s, input logic v, input logic [12:0] d);
    case (s)
      0: begin a_iv = v; a_pi = d[7:0]; end
      1: begin b_iv = v; b_pi = d[7:0]; end
      2: begin c_iv = v; c_pi = d[0]; end
      default: begin d_iv = v; d_pi = d; end
    endcase
  endtask

  task automatic set_rdy(input int s, input logic r);
    case (s)
      0: a_or = r;
      1: b_or = r;
      2: c_or = r;
      default: d_or = r;
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(
    input int s, input logic [12:0] v, input int w,
    input int nc, input int hold, input string tag
  );
    int lat;
    logic [12:0] exp;
    exp = sfx(v, w);
    set_in(s, 1'b1, v);
    tick;
    set_in(s, 1'b0, '0);
    chk({tag, "_busy"}, get_ir(s), 1'b0);
    lat = 0;
    while (!get_ov(s) && lat < 64) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, nc);
    chk({tag, "_po"}, get_po(s), exp);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk({tag, "_hold"}, get_po(s), exp);
    end
    set_rdy(s, 1'b1);
    tick;
    set_rdy(s, 1'b0);
    chk({tag, "_exit_ov"}, get_ov(s), 1'b0);
    chk({tag, "_exit_ir"}, get_ir(s), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      set_in(s, 1'b0, '0);
      set_rdy(s, 1'b0);
    end
    #12;
    chk("rst_ov", a_ov, 1'b0);
    chk("rst_ir", a_ir, 1'b1);
    chk("rst_po", a_po, 8'h00);
    rst_n = 1'b1;

    set_in(0, 1'b1, 13'h0FF);
    tick;
    set_in(0, 1'b0, '0);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", a_ov, 1'b0);
    chk("midrst_po", a_po, 8'h00);
    chk("midrst_ir", a_ir, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_ov", a_ov, 1'b0);
    end

    run_word(0, 13'h0EF, 8, 3, 0, "a_ef");
    run_word(0, 13'h0FF, 8, 3, 1, "a_ff");
    run_word(0, 13'h07F, 8, 3, 0, "a_7f");
    run_word(0, 13'h080, 8, 3, 0, "a_80");
    chk("a_80_model", sfx(13'h080, 8), 13'h080);
    run_word(1, 13'h0EF, 8, 2, 0, "b_ef");
    run_word(1, 13'h0F7, 8, 2, 0, "b_f7");

    set_in(0, 1'b1, 13'h0EF);
    tick;
    set_in(0, 1'b0, '0);
    repeat (3) tick;
    chk("bp_ov", a_ov, 1'b1);
    chk("bp_po", a_po, 8'hE0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 13'h000);
      tick;
      chk("bp_hold_po", a_po, 8'hE0);
      chk("bp_hold_ir", a_ir, 1'b0);
      chk("bp_hold_ov", a_ov, 1'b1);
    end
    set_rdy(0, 1'b1);
    tick;
    set_rdy(0, 1'b0);
    chk("bp_exit_ir", a_ir, 1'b1);
    chk("bp_exit_ov", a_ov, 1'b0);
    tick;
    chk("bp_next_acc", a_ir, 1'b0);
    set_in(0, 1'b0, '0);
    repeat (3) tick;
    chk("bp_next_ov", a_ov, 1'b1);
    chk("bp_next_po", a_po, 8'h00);
    set_rdy(0, 1'b1);
    tick;
    set_rdy(0, 1'b0);

    run_word(2, 13'h001, 1, 1, 0, "c_one");
    run_word(2, 13'h000, 1, 1, 0, "c_zero");

    for (int n = 0; n < 1000; n++) begin
      logic [12:0] v;
      v = 13'($urandom);
      if (n % 4 == 0) v = v | 13'h1F80;
      run_word(3, v, 13, 4, int'($urandom_range(0, 2)), "d_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/au_suffix_and_seq.md
Name: au_suffix_and_seq

Overview:
- Sequential, handshaked companion to the combinational prefix-AND unit, running in the opposite direction.
- Computes the suffix-AND (MSB-to-LSB running AND) of a propagate word: po[i] = AND of pi[WIDTH-1:i].
- Uses a log-depth Kogge-Stone style recurrence, evaluating LVL_PER_CYC levels per clock on a single register.
- Used by right-to-left arithmetic units (leading-ones detection, normalisation) where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, word length of pi/po (>= 1).
- LVL_PER_CYC, 1, prefix levels evaluated per clock (1 to max(1, L)), where L = ceil(log2(WIDTH)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pi is valid.
- in_ready  output  1  block can accept pi.
- pi  input  WIDTH  propagate input word.
- out_valid  output  1  po is valid.
- out_ready  input  1  downstream accepts po.
- po  output  WIDTH  suffix-AND result.

Behaviour:
- Constants: L = ceil(log2(WIDTH)), which is 0 for WIDTH = 1. NC = max(1, ceil(L / LVL_PER_CYC)) compute cycles.
- FSM states: IDLE, CALC, DONE.
- Reset (rst_n low, asynchronous, at any time including mid-CALC):
  - state = IDLE, working register = 0, level counter = 0.
  - po = 0, out_valid = 0, in_ready = 1.
  - Any in-flight word is discarded.
- Outputs are decoded from state:
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - po = working register while in DONE, else 0.
- IDLE:
  - On in_valid & in_ready: load register <= pi, level counter k <= 0, go to CALC.
- CALC, each cycle:
  - Apply levels k .. min(k+LVL_PER_CYC, L)-1 in order.
  - Level j: p[i] <= p[i] & p[i + 2^j] for i + 2^j < WIDTH; bits with i + 2^j >= WIDTH are unchanged.
  - k advances by LVL_PER_CYC. After the last level is applied, go to DONE.
  - For WIDTH = 1 the single CALC cycle is a pass-through.
- DONE:
  - po and out_valid hold steady until out_ready is sampled high, then go to IDLE.
  - No bypass: in_ready stays low in the cycle DONE exits, so a new word is accepted no earlier than the following cycle.
- Latency: input accepted at edge n gives out_valid high after edge n+NC. With immediate out_ready, one word completes every NC+2 cycles.
- in_valid and pi are ignored outside IDLE. pi must be stable only on the accepting edge.
- out_ready is ignored outside DONE.
- All-zero and all-one inputs are not special-cased.
- Illegal WIDTH or LVL_PER_CYC triggers an elaboration-time error message and $finish, matching the codebase's existing parameter-check convention.

Decomposition:
- Shared package au_prefix_pkg:
  - function au_clog2(n).
  - function au_num_cycles(width, lpc) returning NC.
  - localparam bounds for LVL_PER_CYC checks.
- Sub-module au_suffix_and_level:
  - Combinational, parameters WIDTH and MAXL, input level index j.
  - Applies one level. Instantiated LVL_PER_CYC times in a chain inside au_suffix_and_seq.
  - Levels j >= L are pass-through.
- FSM and counter stay in the top.

Test Plan:
- Reset then idle: rst_n low mid-CALC with pi=0xFF loaded → immediately out_valid=0, po=0x00, in_ready=1; after release, no spurious out_valid.
- WIDTH=8, LVL_PER_CYC=1:
  - pi=0xEF accepted at edge n → out_valid rises after edge n+3 with po=0xE0.
  - pi=0xFF → po=0xFF.
  - pi=0x7F → po=0x00.
  - pi=0x80 → po=0x80.
- WIDTH=8, LVL_PER_CYC=2: pi=0xEF → out_valid after edge n+2, po=0xE0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → po stable at 0xE0, in_ready=0, new in_valid/pi=0x00 ignored. Raise out_ready → IDLE next cycle; next word is accepted only the cycle after.
- WIDTH=1: pi=1 → po=1 one cycle after accept; pi=0 → po=0.
- WIDTH=13: random back-to-back stream of 1000 words with random out_ready, compared against a behavioural suffix-AND loop → zero mismatches, latency exactly NC=4 each.
